// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: eager-fork controller that broadcasts one ready/valid
// source to NUM_OUT sinks. Each enabled sink takes every token exactly once.
// The source sees in_ready only when all enabled sinks have taken the token.
// Optional feature macro: FANOUT_FORK_STALL_CNT_EN. When it is defined, the
// block counts source stall cycles in stall_cnt; otherwise stall_cnt is 0.
module fanout_fork_ctrl #(
    parameter int unsigned NUM_OUT = 20,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [NUM_OUT-1:0] cfg_mask_in,
    output logic               cfg_busy,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [NUM_OUT-1:0] r_mask;
    logic [NUM_OUT-1:0] r_done;
    logic [NUM_OUT-1:0] w_acc;
    logic [NUM_OUT-1:0] w_sat;
    logic [NUM_OUT-1:0] w_done_nxt;
    logic               w_cfg_load;

    // Per-sink offer, acceptance and token-complete logic, plus done next-state.
    always_comb begin
        out_valid  = '0;
        w_acc      = '0;
        w_sat      = '0;
        in_ready   = 1'b0;
        cfg_busy   = 1'b0;
        w_cfg_load = 1'b0;
        w_done_nxt = r_done;

        out_valid  = r_mask & ~r_done & {NUM_OUT{in_valid & ~flush}};
        w_acc      = out_valid & out_ready;
        w_sat      = ~r_mask | r_done | w_acc;
        in_ready   = (&w_sat) & ~flush;
        cfg_busy   = |r_done;
        w_cfg_load = cfg_wr & ~(|r_done) & ~flush;

        // A source that drops in_valid mid-token leaves w_acc at 0, so done holds.
        if (flush) begin
            w_done_nxt = '0;
        end else if (in_valid && in_ready) begin
            w_done_nxt = '0;
        end else begin
            w_done_nxt = r_done | w_acc;
        end
    end

    // Done flags: remember which sinks already took the current token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= '0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    // Sink-enable mask: writable only between tokens and outside a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (w_cfg_load) begin
            r_mask <= cfg_mask_in;
        end
    end

`ifdef FANOUT_FORK_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles the source was held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    // The source must hold in_valid until the token has reached every enabled sink.
    a_src_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (!flush && (|r_done)) |-> in_valid)
        else $error("source dropped in_valid with a partially delivered token");

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl with NUM_OUT=4, CNT_W=4.
// Each step queues its expected outputs on a scoreboard, and the queue is
// popped and compared once the DUT outputs have settled.
module tb_fanout_fork_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_wr;
    logic [3:0] cfg_mask_in;
    logic       cfg_busy;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      tag;
        logic [3:0] ov;
        logic       ir;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    fanout_fork_ctrl #(
        .NUM_OUT(4),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_mask_in(cfg_mask_in),
        .cfg_busy   (cfg_busy),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push expectation, let combinational outputs settle, then pop and compare.
    task automatic step(input string tag, input logic [3:0] ov, input logic ir, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.ov   = ov;
        e.ir   = ir;
        e.busy = busy;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
            cmp({e.tag, ".in_ready"},  32'(in_ready),  32'(e.ir));
            cmp({e.tag, ".cfg_busy"},  32'(cfg_busy),  32'(e.busy));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt5;
    int exp_cnt20;

    initial begin
`ifdef FANOUT_FORK_STALL_CNT_EN
        exp_cnt5  = 5;
        exp_cnt20 = 15;
`else
        exp_cnt5  = 0;
        exp_cnt20 = 0;
`endif
        rst_n       = 1'b0;
        cfg_wr      = 1'b0;
        cfg_mask_in = 4'b0000;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 4'b0000;

        // Reset state: mask 0 means in_ready is 1
        step("reset", 4'b0000, 1'b1, 1'b0);
        cmp("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;

        // Program full mask
        cfg_wr = 1'b1; cfg_mask_in = 4'b1111;
        step("cfg1111", 4'b0000, 1'b1, 1'b0);
        tick();
        cfg_wr = 1'b0;

        // 1. Full fanout: one-cycle completion, done stays 0
        in_valid = 1'b1; out_ready = 4'b1111;
        step("full.t0", 4'b1111, 1'b1, 1'b0);
        tick();
        step("full.t1", 4'b1111, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        step("idle", 4'b0000, 1'b0, 1'b0);
        tick();

        // 2. Staggered accept with mask 1011
        cfg_wr = 1'b1; cfg_mask_in = 4'b1011;
        step("cfg1011", 4'b0000, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b0;
        in_valid = 1'b1; out_ready = 4'b0001;
        step("stag.c0", 4'b1011, 1'b0, 1'b0);
        tick();
        out_ready = 4'b1000;
        step("stag.c1", 4'b1010, 1'b0, 1'b1);
        tick();
        out_ready = 4'b0010;
        step("stag.c2", 4'b0010, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        step("stag.after", 4'b0000, 1'b0, 1'b0);
        tick();

        // 3. Config gating while a token is partially delivered
        in_valid = 1'b1; out_ready = 4'b0001;
        step("gate.part", 4'b1011, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b1; cfg_mask_in = 4'b0100; out_ready = 4'b0000;
        step("gate.wr", 4'b1010, 1'b0, 1'b1);
        tick();
        cfg_wr = 1'b0;
        step("gate.hold", 4'b1010, 1'b0, 1'b1);
        out_ready = 4'b1010;
        step("gate.done", 4'b1010, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        cfg_wr = 1'b1; cfg_mask_in = 4'b0100;
        step("gate.wr2", 4'b0000, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b0; in_valid = 1'b1;
        step("gate.new", 4'b0100, 1'b0, 1'b0);
        // cfg_wr in the same cycle a token completes from done==0 is accepted
        cfg_wr = 1'b1; cfg_mask_in = 4'b1111; out_ready = 4'b0100;
        step("gate.samecyc", 4'b0100, 1'b1, 1'b0);
        tick();
        cfg_wr = 1'b0; out_ready = 4'b0000;
        step("gate.samecyc.nxt", 4'b1111, 1'b0, 1'b0);

        // 4. Flush mid-token
        out_ready = 4'b0011;
        step("flush.part", 4'b1111, 1'b0, 1'b0);
        tick();
        flush = 1'b1; out_ready = 4'b1111;
        step("flush.cyc", 4'b0000, 1'b0, 1'b1);
        tick();
        flush = 1'b0; out_ready = 4'b0000;
        step("flush.reoffer", 4'b1111, 1'b0, 1'b0);

        // 5. Empty mask drops tokens
        cfg_wr = 1'b1; cfg_mask_in = 4'b0000;
        step("mask0.wr", 4'b1111, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b0;
        step("mask0.drop0", 4'b0000, 1'b1, 1'b0);
        tick();
        step("mask0.drop1", 4'b0000, 1'b1, 1'b0);
        cfg_wr = 1'b1; cfg_mask_in = 4'b1111;
        step("mask0.reload", 4'b0000, 1'b1, 1'b0);
        tick();
        cfg_wr = 1'b0; out_ready = 4'b0001;
        step("rst.part", 4'b1111, 1'b0, 1'b0);
        tick();
        out_ready = 4'b0000;
        step("rst.pre", 4'b1110, 1'b0, 1'b1);
        // Asynchronous reset mid-token, checked before any clock edge
        rst_n = 1'b0;
        step("rst.async", 4'b0000, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;

        // 6. Stall counter
        cfg_wr = 1'b1; cfg_mask_in = 4'b0001;
        step("stall.cfg", 4'b0000, 1'b1, 1'b0);
        tick();
        cfg_wr = 1'b0; in_valid = 1'b1;
        step("stall.start", 4'b0001, 1'b0, 1'b0);
        cmp("stall.cnt0", 32'(stall_cnt), 32'd0);
        repeat (5) tick();
        cmp("stall.cnt5", 32'(stall_cnt), 32'(exp_cnt5));
        repeat (15) tick();
        cmp("stall.cnt20", 32'(stall_cnt), 32'(exp_cnt20));
        flush = 1'b1;
        step("stall.flush", 4'b0000, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        cmp("stall.cleared", 32'(stall_cnt), 32'd0);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
